// File: rtl/cache_line_fill_ctrl.sv
// Miss handler for a 4-line direct-mapped write-back cache: optionally writes back the
// dirty victim line, then fetches the requested line as four 32-bit memory beats.
module cache_line_fill_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] missAddress,
  input  logic              writetomem,
  input  logic [ADDR_W-1:0] victimAddress,
  input  logic [127:0]      dataOutToRam,
  output logic [127:0]      dataInFromRam,
  output logic              fillDone,
  output logic              busy,
  output logic [ADDR_W-1:0] memAddress,
  output logic              memWrite,
  output logic              memRead,
  output logic [31:0]       memWdata,
  input  logic [31:0]       memRdata,
  input  logic              memReady,
  output logic [CNT_W-1:0]  missCount,
  output logic [CNT_W-1:0]  wbCount,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, WB = 2'd1, RD = 2'd2, DONE = 2'd3} state_t;

  state_t              r_state;
  logic [1:0]          r_k;
  logic [ADDR_W-3:0]   r_fill_line;
  logic [ADDR_W-3:0]   r_victim_line;
  logic [127:0]        r_victim_data;
  logic [127:0]        r_fill_data;
  logic                r_fill_done;
  logic                r_busy;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_mem_write;
  logic                r_mem_read;
  logic [31:0]         r_mem_wdata;
  logic [CNT_W-1:0]    r_miss_cnt;
  logic [CNT_W-1:0]    r_wb_cnt;

  logic [1:0]          w_k_next;
  logic                w_unused_offset_bits;

  assign w_k_next             = r_k + 2'd1;
  assign w_unused_offset_bits = ^{missAddress[1:0], victimAddress[1:0]};

  // Memory handshake: a beat completes on any rising edge where the active strobe
  // and memReady are both high; strobe, address and wdata hold until that edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_k           <= 2'd0;
      r_fill_line   <= '0;
      r_victim_line <= '0;
      r_victim_data <= '0;
      r_fill_data   <= '0;
      r_fill_done   <= 1'b0;
      r_busy        <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_write   <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_wdata   <= '0;
      r_miss_cnt    <= '0;
      r_wb_cnt      <= '0;
    end else begin
      r_fill_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_fill_line   <= missAddress[ADDR_W-1:2];
            r_victim_line <= victimAddress[ADDR_W-1:2];
            r_victim_data <= dataOutToRam;
            r_k           <= 2'd0;
            r_busy        <= 1'b1;
            if (r_miss_cnt != {CNT_W{1'b1}}) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
            if (writetomem) begin
              r_state     <= WB;
              r_mem_write <= 1'b1;
              r_mem_addr  <= {victimAddress[ADDR_W-1:2], 2'b00};
              r_mem_wdata <= dataOutToRam[31:0];
            end else begin
              r_state    <= RD;
              r_mem_read <= 1'b1;
              r_mem_addr <= {missAddress[ADDR_W-1:2], 2'b00};
            end
          end
        end
        WB: begin
          if (memReady) begin
            if (r_k == 2'd3) begin
              r_k         <= 2'd0;
              r_state     <= RD;
              r_mem_write <= 1'b0;
              r_mem_read  <= 1'b1;
              r_mem_addr  <= {r_fill_line, 2'b00};
              if (r_wb_cnt != {CNT_W{1'b1}}) r_wb_cnt <= r_wb_cnt + CNT_W'(1);
            end else begin
              r_k         <= w_k_next;
              r_mem_addr  <= {r_victim_line, w_k_next};
              r_mem_wdata <= r_victim_data[{w_k_next, 5'd0} +: 32];
            end
          end
        end
        RD: begin
          if (memReady) begin
            r_fill_data[{r_k, 5'd0} +: 32] <= memRdata;
            if (r_k == 2'd3) begin
              r_k         <= 2'd0;
              r_state     <= DONE;
              r_mem_read  <= 1'b0;
              r_fill_done <= 1'b1;
            end else begin
              r_k        <= w_k_next;
              r_mem_addr <= {r_fill_line, w_k_next};
            end
          end
        end
        DONE: begin
          // A start seen here is dropped; the next request is taken from IDLE.
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dataInFromRam = r_fill_data;
  assign fillDone      = r_fill_done;
  assign busy          = r_busy;
  assign memAddress    = r_mem_addr;
  assign memWrite      = r_mem_write;
  assign memRead       = r_mem_read;
  assign memWdata      = r_mem_wdata;
  assign missCount     = r_miss_cnt;
  assign wbCount       = r_wb_cnt;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_cache_line_fill_ctrl.sv
// Bench for cache_line_fill_ctrl: beat-level reference model with an expected-beat queue,
// plus a CNT_W=2 instance for counter saturation.
module tb_cache_line_fill_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [31:0]  missAddress;
  logic         writetomem;
  logic [31:0]  victimAddress;
  logic [127:0] dataOutToRam;
  logic [127:0] dataInFromRam;
  logic         fillDone;
  logic         busy;
  logic [31:0]  memAddress;
  logic         memWrite;
  logic         memRead;
  logic [31:0]  memWdata;
  logic [31:0]  memRdata;
  logic         memReady;
  logic [15:0]  missCount;
  logic [15:0]  wbCount;
  logic [1:0]   dbg_state;

  logic         s_start;
  logic [31:0]  s_missAddress;
  logic         s_writetomem;
  logic [31:0]  s_victimAddress;
  logic [127:0] s_dataOutToRam;
  logic [127:0] s_dataInFromRam;
  logic         s_fillDone;
  logic         s_busy;
  logic [31:0]  s_memAddress;
  logic         s_memWrite;
  logic         s_memRead;
  logic [31:0]  s_memWdata;
  logic [31:0]  s_memRdata;
  logic         s_memReady;
  logic [1:0]   s_missCount;
  logic [1:0]   s_wbCount;
  logic [1:0]   s_dbg_state;

  int           total = 0;
  int           bad = 0;
  logic [15:0]  m_miss = 16'd0;
  logic [15:0]  m_wb = 16'd0;
  logic [64:0]  exp_q[$];

  cache_line_fill_ctrl #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .missAddress(missAddress),
    .writetomem(writetomem), .victimAddress(victimAddress), .dataOutToRam(dataOutToRam),
    .dataInFromRam(dataInFromRam), .fillDone(fillDone), .busy(busy),
    .memAddress(memAddress), .memWrite(memWrite), .memRead(memRead), .memWdata(memWdata),
    .memRdata(memRdata), .memReady(memReady), .missCount(missCount), .wbCount(wbCount),
    .o_dbg_state(dbg_state)
  );

  cache_line_fill_ctrl #(.ADDR_W(32), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .start(s_start), .missAddress(s_missAddress),
    .writetomem(s_writetomem), .victimAddress(s_victimAddress), .dataOutToRam(s_dataOutToRam),
    .dataInFromRam(s_dataInFromRam), .fillDone(s_fillDone), .busy(s_busy),
    .memAddress(s_memAddress), .memWrite(s_memWrite), .memRead(s_memRead), .memWdata(s_memWdata),
    .memRdata(s_memRdata), .memReady(s_memReady), .missCount(s_missCount), .wbCount(s_wbCount),
    .o_dbg_state(s_dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Main memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Drives one miss and checks every cycle against the expected beat sequence.
  // stall_mode: 0 = memReady always high, 1 = two stall cycles before each beat, 2 = random.
  task automatic do_miss(input logic [31:0] maddr, input logic dirty, input logic [31:0] vaddr,
                         input logic [127:0] vline, input int stall_mode, input int drop_at,
                         input bit drop_done, input int exp_done_cyc);
    logic [31:0]  fbase, vbase;
    logic [127:0] exp_line;
    logic [64:0]  b;
    logic [67:0]  got_b, exp_b;
    logic [131:0] got_d, exp_d;
    logic [163:0] got_i, exp_i;
    int           cyc, stall_left;
    bit           done, rdy;
    fbase = {maddr[31:2], 2'b00};
    vbase = {vaddr[31:2], 2'b00};
    exp_q.delete();
    if (dirty) for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, vbase + 32'(i), vline[32*i +: 32]});
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({1'b0, fbase + 32'(i), 32'h0});
      exp_line[32*i +: 32] = mem_word(fbase + 32'(i));
    end
    if (m_miss != 16'hFFFF) m_miss = m_miss + 16'd1;
    if (dirty && m_wb != 16'hFFFF) m_wb = m_wb + 16'd1;

    start = 1'b1; missAddress = maddr; writetomem = dirty; victimAddress = vaddr;
    dataOutToRam = vline; memReady = 1'($urandom_range(0, 1)); memRdata = $urandom();
    @(posedge clk); #1;
    cyc = 1; done = 1'b0;
    stall_left = (stall_mode == 1) ? 2 : 0;
    while (!done && cyc < 300) begin
      start = 1'b0; memReady = 1'b0; memRdata = $urandom();
      if (cyc == drop_at) begin
        start = 1'b1; missAddress = $urandom(); writetomem = 1'($urandom_range(0, 1));
        victimAddress = $urandom(); dataOutToRam = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      if (exp_q.size() != 0) begin
        b = exp_q[0];
        got_b = {memWrite, memRead, fillDone, busy, memAddress, b[64] ? memWdata : 32'h0};
        exp_b = {b[64], ~b[64], 1'b0, 1'b1, b[63:32], b[64] ? b[31:0] : 32'h0};
        total++;
        if (got_b !== exp_b) begin
          bad++;
          $display("FAIL beat cyc=%0d got wr/rd/done/busy/addr/wdata=%h expected %h", cyc, got_b, exp_b);
        end
        if (stall_mode == 0) rdy = 1'b1;
        else if (stall_mode == 1) rdy = (stall_left == 0);
        else rdy = ($urandom_range(0, 2) != 0);
        if (rdy) begin
          memReady = 1'b1;
          if (!b[64]) memRdata = mem_word(memAddress);
          void'(exp_q.pop_front());
          stall_left = (stall_mode == 1) ? 2 : 0;
        end else if (stall_left > 0) begin
          stall_left--;
        end
      end else begin
        got_d = {memWrite, memRead, fillDone, busy, dataInFromRam};
        exp_d = {4'b0011, exp_line};
        total++;
        if (got_d !== exp_d) begin
          bad++;
          $display("FAIL done_cycle cyc=%0d got %h expected %h", cyc, got_d, exp_d);
        end
        if (exp_done_cyc != 0) begin
          total++;
          if (cyc != exp_done_cyc) begin
            bad++;
            $display("FAIL done_latency got cycle %0d expected cycle %0d", cyc, exp_done_cyc);
          end
        end
        memReady = 1'($urandom_range(0, 1));
        if (drop_done) begin
          start = 1'b1; missAddress = $urandom(); writetomem = 1'b1; victimAddress = $urandom();
        end
        done = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL txn_timeout addr=%h no fillDone within %0d cycles", maddr, cyc);
    end
    start = 1'b0; memReady = 1'b0;
    got_i = {memWrite, memRead, fillDone, busy, dataInFromRam, missCount, wbCount};
    exp_i = {4'b0000, exp_line, m_miss, m_wb};
    total++;
    if (got_i !== exp_i) begin
      bad++;
      $display("FAIL idle_after got %h expected %h", got_i, exp_i);
    end
  endtask

  task automatic test_reset;
    logic [228:0] got_r;
    got_r = {memWrite, memRead, fillDone, busy, memAddress, memWdata, dataInFromRam, missCount, wbCount,
             s_missCount, s_wbCount, s_busy};
    total++;
    if (got_r !== '0) begin
      bad++;
      $display("FAIL reset_values got %h expected 0", got_r);
    end
  endtask

  task automatic test_clean_miss;
    do_miss(32'h0000_0016, 1'b0, 32'h0, 128'h0, 0, 0, 1'b0, 5);
  endtask

  task automatic test_dirty_miss;
    do_miss(32'h0000_0024, 1'b1, 32'h0000_0008, 128'hD3D3_0003_D2D2_0002_D1D1_0001_D0D0_0000, 0, 0, 1'b0, 9);
  endtask

  task automatic test_wait_states;
    do_miss(32'h0000_1230, 1'b0, 32'h0, 128'h0, 1, 0, 1'b0, 13);
  endtask

  task automatic test_busy_drop;
    do_miss(32'h0000_0041, 1'b0, 32'h0, 128'h0, 0, 3, 1'b1, 5);
  endtask

  task automatic test_back_to_back;
    do_miss(32'h0000_0100, 1'b1, 32'h0000_0200, {$urandom(), $urandom(), $urandom(), $urandom()}, 0, 0, 1'b0, 9);
    do_miss(32'h0000_0300, 1'b0, 32'h0, 128'h0, 0, 0, 1'b0, 5);
  endtask

  task automatic test_wrap;
    do_miss(32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFE, {$urandom(), $urandom(), $urandom(), $urandom()}, 2, 0, 1'b0, 0);
  endtask

  task automatic test_random;
    for (int n = 0; n < 20; n++)
      do_miss($urandom(), 1'($urandom_range(0, 1)), $urandom(),
              {$urandom(), $urandom(), $urandom(), $urandom()}, 2, int'($urandom_range(0, 6)),
              1'($urandom_range(0, 1)), 0);
  endtask

  task automatic test_reset_mid_wb;
    logic [291:0] got_r;
    start = 1'b1; missAddress = 32'h0000_0500; writetomem = 1'b1; victimAddress = 32'h0000_0600;
    dataOutToRam = {$urandom(), $urandom(), $urandom(), $urandom()}; memReady = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; memReady = 1'b0;
    got_r = {memWrite, memRead, fillDone, busy, memAddress, memWdata, dataInFromRam, missCount, wbCount};
    total++;
    if (got_r !== '0) begin
      bad++;
      $display("FAIL reset_mid_wb got %h expected 0", got_r);
    end
    m_miss = 16'd0; m_wb = 16'd0;
    do_miss(32'h0000_0777, 1'b0, 32'h0, 128'h0, 0, 0, 1'b0, 5);
  endtask

  task automatic test_saturation;
    logic [3:0] got_s, exp_s;
    int         c;
    for (int n = 1; n <= 5; n++) begin
      s_start = 1'b1; s_missAddress = $urandom(); s_writetomem = 1'b1; s_victimAddress = $urandom();
      @(posedge clk); #1;
      s_start = 1'b0;
      c = 0;
      while (!s_fillDone && c < 50) begin
        @(posedge clk); #1;
        c++;
      end
      if (!s_fillDone) begin
        total++; bad++;
        $display("FAIL sat_timeout miss=%0d", n);
      end
      @(posedge clk); #1;
      got_s = {s_missCount, s_wbCount};
      exp_s = (n >= 3) ? 4'b1111 : {2'(n), 2'(n)};
      total++;
      if (got_s !== exp_s) begin
        bad++;
        $display("FAIL saturation miss=%0d got miss/wb=%h expected %h", n, got_s, exp_s);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; missAddress = '0; writetomem = 1'b0; victimAddress = '0;
    dataOutToRam = '0; memRdata = '0; memReady = 1'b0;
    s_start = 1'b0; s_missAddress = '0; s_writetomem = 1'b0; s_victimAddress = '0;
    s_dataOutToRam = 128'h1111_2222_3333_4444_5555_6666_7777_8888; s_memRdata = 32'hCAFE_0001;
    s_memReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    reset = 1'b0;
    test_clean_miss;
    test_dirty_miss;
    test_wait_states;
    test_busy_drop;
    test_back_to_back;
    test_wrap;
    test_random;
    test_reset_mid_wb;
    test_saturation;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_line_fill_ctrl.md
# cache_line_fill_ctrl

Miss handler placed directly downstream of the 4-line direct-mapped write-back cache. On a miss it optionally writes back the dirty 128-bit victim line and then fetches the requested 128-bit line. Main memory sits on a single-word (32-bit) handshaked bus, so each line moves as four word beats. The assembled line is returned to the cache as `dataInFromRam`.

## Interface
- ADDR_W, 32, word-address width on both sides
- CNT_W, 16, width of the saturating statistics counters
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request pulse from cache; ignored unless `busy`=0
- missAddress  in  ADDR_W  word address of requested word; [1:0] = word offset
- writetomem  in  1  victim dirty; sampled with `start`
- victimAddress  in  ADDR_W  word address of victim line; [1:0] ignored
- dataOutToRam  in  128  victim line; word k = bits [32k+31:32k]
- dataInFromRam  out  128  filled line, registered; same word packing
- fillDone  out  1  one-cycle pulse, `dataInFromRam` valid from this cycle
- busy  out  1  high whenever state ≠ IDLE
- memAddress  out  ADDR_W  beat address
- memWrite  out  1  write strobe
- memRead  out  1  read strobe
- memWdata  out  32  write data
- memRdata  in  32  read data, valid when `memReady`=1 during a read beat
- memReady  in  1  beat completes on a cycle where strobe=1 and `memReady`=1
- missCount  out  CNT_W  accepted requests, saturating
- wbCount  out  CNT_W  completed write-backs, saturating

## Operation
- States: IDLE, WB, RD, DONE. 2-bit beat counter `k`.
- IDLE, `start`=1:
  - latch fill base {missAddress[ADDR_W-1:2],2'b00}, victim base {victimAddress[ADDR_W-1:2],2'b00}, `dataOutToRam`, and `writetomem`;
  - `k`←0; `missCount`++.
  - Next state is WB if `writetomem`=1, else RD.
- WB: `memWrite`=1, `memAddress`=victim base+`k`, `memWdata`=latched word k.
  - On `memReady`: `k`++.
  - On the beat with `k`=3: `k`←0, `wbCount`++, go to RD.
- RD: `memRead`=1, `memAddress`=fill base+`k`.
  - On `memReady`: `dataInFromRam`[32k+31:32k]←`memRdata`, `k`++.
  - On the beat with `k`=3: go to DONE.
- DONE: `fillDone`=1 for exactly one cycle, then IDLE.
- `memWrite` and `memRead` are never high together. Both are low in IDLE and DONE.
- Strobes, address and wdata are stable while `memReady`=0. The block waits indefinitely; there is no timeout.
- `start` while `busy`=1 is dropped and not counted. `start` in the DONE cycle is also dropped.
- `dataInFromRam` holds its value until overwritten beat-by-beat by the next RD. It is not cleared at IDLE.
- Address arithmetic is modulo 2^ADDR_W. The base has [1:0]=0, so base+3 never carries out of the line.
- Counters stick at 2^CNT_W−1.

## Timing
- Reset values:
  - state IDLE, `k`=0;
  - `busy`, `fillDone`, `memWrite`, `memRead` = 0;
  - `memAddress`, `memWdata`, `dataInFromRam`, `missCount`, `wbCount` = 0.
- `start` is sampled at edge 0. The strobe is high from cycle 1.
- With `memReady` tied high:
  - clean miss: RD beats in cycles 1–4, `fillDone` in cycle 5;
  - dirty miss: WB beats in cycles 1–4, RD in 5–8, `fillDone` in cycle 9.
- Each cycle of `memReady`=0 adds one cycle of latency.
- `busy`=1 from cycle 1 through the DONE cycle inclusive. A new `start` is accepted in the first cycle after DONE.
- Reset asserted mid-transaction returns all state and outputs to reset values at that edge.
  - No `fillDone` is issued and partial fill data is discarded.
  - Counters reset, and no count is credited for the aborted write-back.
- Outputs are registered. There is no combinational path from `memReady` or `memRdata` to any output.

## Test plan
- **Clean miss**, `memReady`=1:
  - stimulus: `start` with `missAddress`=0x0000_0016, memory words 0x14..0x17 = A0,A1,A2,A3;
  - response: reads at addresses 0x14–0x17 in cycles 1–4, `fillDone` in cycle 5, `dataInFromRam`={A3,A2,A1,A0}, `missCount`=1, `wbCount`=0.
- **Dirty miss**:
  - stimulus: `writetomem`=1, `victimAddress`=0x0000_0008, `dataOutToRam`={D3,D2,D1,D0}, `missAddress`=0x24;
  - response: writes D0–D3 to 0x08–0x0B, then reads 0x24–0x27, `fillDone` in cycle 9, `wbCount`=1.
- **Wait states**:
  - stimulus: `memReady` low for 2 cycles before each beat of a clean miss;
  - response: the strobe and its address hold during stalls, `fillDone` arrives in cycle 13, data is correct.
- **Busy drop**:
  - stimulus: second `start` in cycle 3 of a transaction and in its DONE cycle;
  - response: both ignored, `missCount`=1, no extra memory beats.
- **Reset mid-write-back**:
  - stimulus: `reset` in cycle 2 of a dirty miss;
  - response: next cycle all strobes are 0, `busy`=0, counters are 0, no `fillDone`, and a new `start` proceeds normally.
- **Wrap and saturation**:
  - `missAddress`=0xFFFF_FFFD reads 0xFFFF_FFFC–0xFFFF_FFFF.
  - With CNT_W=2, 5 misses give `missCount`=3.
